// File: rtl/mmul_tile_controller_if.sv
// Handshake bundle between the tile controller, the A/B input slaves,
// the systolic array and the result output master.
interface mmul_tile_controller_if #(
  parameter int N     = 4,
  parameter int K_MAX = 256
);
  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = $clog2(N);

  logic          start;
  logic [KW-1:0] k_len;
  logic          busy;
  logic          done;
  logic          a_valid;
  logic          a_ready;
  logic          b_valid;
  logic          b_ready;
  logic          arr_en;
  logic          arr_clear;
  logic          arr_feed_zero;
  logic [RW-1:0] res_row_sel;
  logic          res_valid;
  logic          res_ready;

  modport master (
    input  start, k_len, a_valid, b_valid, res_ready,
    output busy, done, a_ready, b_ready,
    output arr_en, arr_clear, arr_feed_zero,
    output res_row_sel, res_valid
  );

  modport slave (
    output start, k_len, a_valid, b_valid, res_ready,
    input  busy, done, a_ready, b_ready,
    input  arr_en, arr_clear, arr_feed_zero,
    input  res_row_sel, res_valid
  );
endinterface

// File: rtl/mmul_tile_controller.sv
// Output-stationary NxN systolic tile sequencer:
// clear, joint A/B feed, drain, row readout.
module mmul_tile_controller #(
  parameter int N     = 4,
  parameter int K_MAX = 256
) (
  input logic                   clk,
  input logic                   reset_n,
  mmul_tile_controller_if.master bus
);
  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = $clog2(N);
  localparam int DW = $clog2(2 * N);
  localparam int CW = (KW > DW) ? KW : DW;

  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] KMAX_C = CW'(K_MAX);
  localparam logic [CW-1:0] DLAST  = CW'(2 * N - 2);
  localparam logic [CW-1:0] RLAST  = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, FEED, DRAIN, OUTPUT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] kl;
  logic [CW-1:0] kext;
  logic          done_q;
  logic          fire;

  assign kext = CW'(bus.k_len);
  assign fire = bus.a_valid & bus.b_valid;

  // One shared counter: beats in FEED, cycles in DRAIN, rows in OUTPUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      kl     <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.k_len == '0) begin
              done_q <= 1'b1;
            end else begin
              kl    <= (kext > KMAX_C) ? KMAX_C : kext;
              state <= CLEAR;
            end
          end
        end
        CLEAR: begin
          cnt   <= '0;
          state <= FEED;
        end
        FEED: begin
          if (fire) begin
            if (cnt == kl - ONE) begin
              cnt   <= '0;
              state <= DRAIN;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        DRAIN: begin
          if (cnt == DLAST) begin
            cnt   <= '0;
            state <= OUTPUT;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        OUTPUT: begin
          if (bus.res_ready) begin
            if (cnt == RLAST) begin
              cnt    <= '0;
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ready is cross-coupled to the other stream's valid: no comb loop.
  always_comb begin
    bus.busy          = (state != IDLE);
    bus.done          = done_q;
    bus.a_ready       = 1'b0;
    bus.b_ready       = 1'b0;
    bus.arr_en        = 1'b0;
    bus.arr_clear     = 1'b0;
    bus.arr_feed_zero = 1'b0;
    bus.res_valid     = 1'b0;
    bus.res_row_sel   = '0;
    unique case (state)
      CLEAR: bus.arr_clear = 1'b1;
      FEED: begin
        bus.a_ready = bus.b_valid;
        bus.b_ready = bus.a_valid;
        bus.arr_en  = fire;
      end
      DRAIN: begin
        bus.arr_en        = 1'b1;
        bus.arr_feed_zero = 1'b1;
      end
      OUTPUT: begin
        bus.res_valid   = 1'b1;
        bus.res_row_sel = cnt[RW-1:0];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mmul_tile_controller.sv
// Bench for mmul_tile_controller: per-cycle output check
// against a timeline predicted from the stimulus arrays.
module tb_mmul_tile_controller;
  localparam int N     = 4;
  localparam int K_MAX = 256;
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int RW    = $clog2(N);
  localparam int VW    = RW + 8;
  localparam int MAXC  = 1500;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mmul_tile_controller_if #(.N(N), .K_MAX(K_MAX)) bus ();

  mmul_tile_controller #(.N(N), .K_MAX(K_MAX)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit st [MAXC];
  bit av [MAXC];
  bit bv [MAXC];
  bit rr [MAXC];
  logic [VW-1:0] exp_v [MAXC];
  int span;

  function automatic logic [VW-1:0] pack(
    bit busy, bit done, bit ar, bit br, bit en,
    bit clr, bit fz, bit rv, int row
  );
    return {busy, done, ar, br, en, clr, fz, rv,
            RW'(row)};
  endfunction

  function automatic logic [VW-1:0] observe();
    return {bus.busy, bus.done, bus.a_ready,
            bus.b_ready, bus.arr_en, bus.arr_clear,
            bus.arr_feed_zero, bus.res_valid,
            bus.res_row_sel};
  endfunction

  task automatic fill(int pa, int pb, int pr);
    for (int t = 0; t < MAXC; t++) begin
      st[t] = 1'b0;
      av[t] = ($urandom_range(99) < pa);
      bv[t] = ($urandom_range(99) < pb);
      rr[t] = ($urandom_range(99) < pr);
    end
    st[0] = 1'b1;
  endtask

  // Timeline: clear at 1, kl fires from 2, 2N-1 drain cycles,
  // then N accepted rows, done the cycle after the last row.
  task automatic model(int kreq);
    int kl;
    int t;
    int fires;
    int rows;
    bit f;
    kl = (kreq > K_MAX) ? K_MAX : kreq;
    for (int i = 0; i < MAXC; i++) exp_v[i] = '0;
    if (kl == 0) begin
      exp_v[1] = pack(0, 1, 0, 0, 0, 0, 0, 0, 0);
      span = 4;
      return;
    end
    exp_v[1] = pack(1, 0, 0, 0, 0, 1, 0, 0, 0);
    t = 2;
    fires = 0;
    while (fires < kl && t < MAXC - 4 * N) begin
      f = av[t] & bv[t];
      exp_v[t] = pack(1, 0, bv[t], av[t], f, 0, 0, 0, 0);
      fires += int'(f);
      t++;
    end
    for (int d = 0; d < 2 * N - 1; d++) begin
      exp_v[t] = pack(1, 0, 0, 0, 1, 0, 1, 0, 0);
      t++;
    end
    rows = 0;
    while (rows < N && t < MAXC - 3) begin
      exp_v[t] = pack(1, 0, 0, 0, 0, 0, 0, 1, rows);
      if (rr[t]) rows++;
      t++;
    end
    exp_v[t] = pack(0, 1, 0, 0, 0, 0, 0, 0, 0);
    span = t + 3;
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.k_len     = '0;
    bus.a_valid   = 1'b0;
    bus.b_valid   = 1'b0;
    bus.res_ready = 1'b0;
  endtask

  // Called just after a posedge with the DUT idle.
  task automatic drive(string name, int kreq);
    logic [VW-1:0] obs;
    for (int t = 0; t < span; t++) begin
      bus.start     = st[t];
      bus.k_len     = KW'(kreq);
      bus.a_valid   = av[t];
      bus.b_valid   = bv[t];
      bus.res_ready = rr[t];
      @(negedge clk);
      obs = observe();
      n_checks++;
      if (obs !== exp_v[t]) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %b expected %b",
                 name, t, obs, exp_v[t]);
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [VW-1:0] obs;
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    obs = observe();
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset: got %b expected 0", obs);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    fill(100, 100, 100);
    model(3);
    drive("basic_k3", 3);
  endtask

  task automatic test_stall();
    fill(100, 100, 100);
    bv[3] = 1'b0;
    bv[4] = 1'b0;
    model(3);
    drive("feed_stall", 3);
  endtask

  task automatic test_backpressure();
    fill(100, 100, 100);
    for (int t = 12; t < MAXC; t++) rr[t] = ((t - 12) % 2 == 1);
    model(3);
    drive("backpressure", 3);
  endtask

  task automatic test_k_bounds();
    fill(100, 100, 100);
    model(0);
    drive("k_zero", 0);
    fill(100, 100, 100);
    model(300);
    drive("k_clamp", 300);
    fill(100, 100, 100);
    model(1);
    drive("k_one", 1);
  endtask

  task automatic test_start_busy();
    fill(100, 100, 100);
    st[6] = 1'b1;
    model(3);
    drive("start_busy", 3);
  endtask

  task automatic test_async_reset();
    logic [VW-1:0] obs;
    fill(100, 100, 100);
    bus.k_len     = KW'(10);
    bus.a_valid   = 1'b1;
    bus.b_valid   = 1'b1;
    bus.res_ready = 1'b1;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    obs = observe();
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected 0",
               obs);
    end
    idle_inputs();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    model(2);
    drive("after_reset_k2", 2);
  endtask

  task automatic test_random_tiles();
    int k;
    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(20, 1);
      fill($urandom_range(100, 30),
           $urandom_range(100, 30),
           $urandom_range(100, 30));
      model(k);
      drive("random_tile", k);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_backpressure();
    test_k_bounds();
    test_start_busy();
    test_async_reset();
    test_random_tiles();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
